// File: rtl/beat_tone_pkg.sv
// Shared constants for the buzzer back end: note table, divisor helper and FSM states.
// The sequencer's bench imports this too, so keep it free of design-specific state.
package beat_tone_pkg;

    localparam int BEAT_W = 13;
    localparam int IDX_W  = 4;

    // Equal-tempered C4..C5 (A4 = 440 Hz), in milli-Hz so the table stays integral.
    localparam longint unsigned NOTE_MHZ [BEAT_W] = '{
        64'd261626, 64'd277183, 64'd293665, 64'd311127, 64'd329628,
        64'd349228, 64'd369994, 64'd391995, 64'd415305, 64'd440000,
        64'd466164, 64'd493883, 64'd523251
    };

    // Half-period in clock cycles, rounded to nearest: round(clk_hz / (2 * f)).
    function automatic longint unsigned half_div(input longint unsigned clk_hz,
                                                 input int unsigned     idx);
        longint unsigned f_mhz;
        f_mhz = NOTE_MHZ[idx];
        return (clk_hz * 64'd1000 + f_mhz) / (64'd2 * f_mhz);
    endfunction

    typedef enum logic {
        SILENT = 1'b0,
        PLAY   = 1'b1
    } state_e;

endpackage

// File: rtl/beat_decode.sv
// One-hot note code classifier: rest (no bits), a single note index, or a
// multi-bit code. Purely combinational so other benches can reuse it as a checker.
module beat_decode
    import beat_tone_pkg::*;
(
    input  logic [BEAT_W-1:0] beat_i,
    output logic [IDX_W-1:0]  idx_o,
    output logic              valid_o,
    output logic              multi_o
);

    logic [IDX_W-1:0] ones;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a path that skips one would infer a latch.
    always_comb begin
        idx_o = '0;
        ones  = '0;
        for (int i = 0; i < BEAT_W; i++) begin
            if (beat_i[i]) begin
                idx_o = IDX_W'(i);
                ones  = ones + IDX_W'(1);
            end
        end
    end

    assign valid_o = (ones == IDX_W'(1));
    assign multi_o = (ones > IDX_W'(1));

endmodule

// File: rtl/beat_tone_gen.sv
// Buzzer/LED back end of the alarm sequencer: turns the registered one-hot beat
// code into a 50% square wave at the note's pitch and re-times the LED request.
module beat_tone_gen
    import beat_tone_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned DIV_W  = 17
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [BEAT_W-1:0] beat,
    input  logic              light,
    output logic              tone,
    output logic              led,
    output logic              active,
    output logic [IDX_W-1:0]  note,
    output logic              note_chg,
    output logic              bad_beat
);

    // Lowest note has the longest half-period; highest note the shortest.
    if (half_div(64'(CLK_HZ), BEAT_W - 1) < 64'd1 ||
        half_div(64'(CLK_HZ), 0) >= (64'd1 << DIV_W)) begin : g_bad_div
        $error("beat_tone_gen: half-period divisor out of range for CLK_HZ/DIV_W");
    end

    logic [DIV_W-1:0] half_tbl [BEAT_W];

    for (genvar g = 0; g < BEAT_W; g++) begin : g_div
        localparam longint unsigned HD = half_div(64'(CLK_HZ), g);
        assign half_tbl[g] = DIV_W'(HD);
    end

    logic [BEAT_W-1:0] beat_q, beat_last_q;
    logic              light_q;
    state_e            state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic              tone_q, tone_d;
    logic [IDX_W-1:0]  note_q, note_d;
    logic              note_chg_q, note_chg_d;
    logic              bad_q, bad_d;

    logic [IDX_W-1:0]  dec_idx;
    logic              dec_valid, dec_multi;
    logic [DIV_W-1:0]  half;

    beat_decode u_decode (
        .beat_i  (beat_q),
        .idx_o   (dec_idx),
        .valid_o (dec_valid),
        .multi_o (dec_multi)
    );

    assign half = half_tbl[dec_idx];

    always_comb begin
        state_d    = SILENT;
        note_d     = '0;
        cnt_d      = '0;
        tone_d     = 1'b0;
        note_chg_d = (beat_q != beat_last_q);
        bad_d      = bad_q | dec_multi;

        // A fresh note (change or entry to PLAY) keeps the cleared defaults,
        // which also wins over a coincident terminal count.
        if (dec_valid) begin
            state_d = PLAY;
            note_d  = dec_idx;
            if (!note_chg_d && state_q == PLAY) begin
                if (cnt_q == half - DIV_W'(1)) begin
                    tone_d = ~tone_q;
                end else begin
                    cnt_d  = cnt_q + DIV_W'(1);
                    tone_d = tone_q;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            beat_q      <= '0;
            beat_last_q <= '0;
            light_q     <= 1'b0;
            state_q     <= SILENT;
            cnt_q       <= '0;
            tone_q      <= 1'b0;
            note_q      <= '0;
            note_chg_q  <= 1'b0;
            bad_q       <= 1'b0;
        end else begin
            beat_q      <= beat;
            beat_last_q <= beat_q;
            light_q     <= light;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tone_q      <= tone_d;
            note_q      <= note_d;
            note_chg_q  <= note_chg_d;
            bad_q       <= bad_d;
        end
    end

    // Muting gates only the pin; the counter keeps running so unmute resumes mid-phase.
    assign active   = (state_q == PLAY);
    assign tone     = tone_q & enable & active;
    assign led      = light_q;
    assign note     = note_q;
    assign note_chg = note_chg_q;
    assign bad_beat = bad_q;

endmodule

// File: tb/tb_beat_tone_gen.sv
// Scoreboard bench for beat_tone_gen at CLK_HZ = 1 MHz: stimulus queues the expected
// note-change pulses and tone edges, a negedge monitor pops and compares them.
module tb_beat_tone_gen;

    localparam int HALF_A4 = 1136;  // round(1e6 / 880)
    localparam int HALF_C5 = 956;   // round(1e6 / 1046.502)
    localparam logic [12:0] B_A4  = 13'h0200;
    localparam logic [12:0] B_C5  = 13'h1000;
    localparam logic [12:0] B_BAD = 13'b0000100100000;

    logic        clk = 1'b0;
    logic        rst, enable, light;
    logic [12:0] beat;
    logic        tone, led, active, note_chg, bad_beat;
    logic [3:0]  note;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_on = 1'b0;
    logic tone_prev = 1'b0;

    typedef enum int {EV_CHG, EV_TONE} ev_e;
    typedef struct {
        ev_e kind;
        int  cyc;
        int  note;
        int  active;
        int  tone;
    } exp_t;
    exp_t sb[$];

    beat_tone_gen #(.CLK_HZ(1_000_000), .DIV_W(17)) dut (
        .clock    (clk),
        .reset    (rst),
        .enable   (enable),
        .beat     (beat),
        .light    (light),
        .tone     (tone),
        .led      (led),
        .active   (active),
        .note     (note),
        .note_chg (note_chg),
        .bad_beat (bad_beat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push_chg(input int c, input int n, input int a);
        sb.push_back('{EV_CHG, c, n, a, 0});
    endfunction

    function automatic void push_tone(input int c, input int v);
        sb.push_back('{EV_TONE, c, 0, 0, v});
    endfunction

    task automatic take(input ev_e kind);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got %s at cycle %0d expected none", kind.name(), cyc);
            return;
        end
        e = sb.pop_front();
        check("event_kind", kind, e.kind);
        check("event_cycle", cyc, e.cyc);
        if (kind == EV_CHG) begin
            check("chg_note", note, e.note);
            check("chg_active", active, e.active);
        end else begin
            check("tone_level", tone, e.tone);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (note_chg !== 1'b0) take(EV_CHG);
            if (tone !== tone_prev) take(EV_TONE);
            tone_prev = tone;
        end
    end

    // Returns 1 time unit after edge n, with cyc == n.
    task automatic tick_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int   t;
        int   s;
        logic prev;

        rst = 1'b1; enable = 1'b0; light = 1'b0; beat = '0;
        tick_to(3);
        rst = 1'b0;
        tone_prev = tone;
        mon_on = 1'b1;
        check("rst_tone", tone, 0);
        check("rst_active", active, 0);
        check("rst_note", note, 0);
        check("rst_note_chg", note_chg, 0);
        check("rst_bad_beat", bad_beat, 0);
        check("rst_led", led, 0);

        // Idle with rest code; led lags light by one cycle.
        prev = 1'b0;
        for (int i = 0; i < 100; i++) begin
            check("led_lag", led, prev);
            light = ((i % 5) < 2);
            prev  = light;
            tick_to(cyc + 1);
        end
        light = 1'b0;
        check("idle_tone", tone, 0);
        check("idle_active", active, 0);
        check("idle_note", note, 0);
        check("idle_bad_beat", bad_beat, 0);

        // A4 from silence.
        enable = 1'b1;
        t = cyc; beat = B_A4; s = t + 2;
        push_chg(s, 9, 1);
        push_tone(s + HALF_A4, 1);
        push_tone(s + 2 * HALF_A4, 0);
        push_tone(s + 3 * HALF_A4, 1);
        tick_to(s + 10);
        check("a4_note", note, 9);

        // Switch to C5 while tone is high: forced low, fresh C5 phase.
        t = s + 3 * HALF_A4 + 500; tick_to(t);
        beat = B_C5; s = t + 2;
        push_chg(s, 12, 1);
        push_tone(s, 0);
        push_tone(s + HALF_C5, 1);
        push_tone(s + 2 * HALF_C5, 0);

        // Multi-bit code: treated as rest, sticky flag.
        t = s + 2 * HALF_C5 + 100; tick_to(t);
        check("c5_note", note, 12);
        beat = B_BAD; s = t + 2;
        push_chg(s, 0, 0);
        tick_to(s + 1);
        check("bad_flag", bad_beat, 1);
        check("bad_tone", tone, 0);
        check("bad_active", active, 0);
        t = s + 50; tick_to(t);
        check("bad_tone_hold", tone, 0);
        beat = B_A4; s = t + 2;
        push_chg(s, 9, 1);
        push_tone(s + HALF_A4, 1);
        tick_to(s + 1);
        check("bad_sticky", bad_beat, 1);

        // Mute during the high half for 500 cycles; phase keeps running.
        t = s + HALF_A4 + 200; tick_to(t);
        enable = 1'b0;
        push_tone(t, 0);
        tick_to(t + 250);
        check("mute_tone", tone, 0);
        check("mute_active", active, 1);
        t = t + 500; tick_to(t);
        enable = 1'b1;
        push_tone(t, 1);
        push_tone(s + 2 * HALF_A4, 0);
        push_tone(s + 3 * HALF_A4, 1);

        // C5, then a one-cycle reset while tone is high.
        t = s + 3 * HALF_A4 + 100; tick_to(t);
        beat = B_C5; s = t + 2;
        push_chg(s, 12, 1);
        push_tone(s, 0);
        push_tone(s + HALF_C5, 1);
        t = s + HALF_C5 + 100; tick_to(t);
        rst = 1'b1;
        push_tone(t + 1, 0);
        tick_to(t + 1);
        rst = 1'b0;
        check("rst2_tone", tone, 0);
        check("rst2_active", active, 0);
        check("rst2_note", note, 0);
        check("rst2_note_chg", note_chg, 0);
        check("rst2_bad_beat", bad_beat, 0);
        check("rst2_led", led, 0);
        s = t + 3;
        push_chg(s, 12, 1);
        push_tone(s + HALF_C5, 1);
        tick_to(s + HALF_C5 + 10);

        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
